serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequences a single one-bit full-adder cell (Sum = a^b^Cin,
//   Cout = (a^b)&Cin | a&b) over WIDTH-bit operands, LSB first, one bit per clock.
//   Supports add and subtract (two's complement) and reports carry and signed overflow.
//   Sits between a requester issuing start pulses and the shared full-adder cell.
//   Trades latency for area: one adder cell replaces a WIDTH-bit ripple adder.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//   clk       in   1      system clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request; sampled only when busy==0
//   sub       in   1      0 = A+B, 1 = A-B; sampled with start
//   A         in   WIDTH  operand A; sampled with start
//   B         in   WIDTH  operand B; sampled with start
//   busy      out  1      high while an operation is in progress (state RUN)
//   done      out  1      one-cycle pulse; Sum/Cout/Ovf are valid from this cycle on
//   Sum       out  WIDTH  result, registered
//   Cout      out  1      final carry; for subtract, 1 = no borrow (A>=B unsigned)
//   Ovf       out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Clock and reset
//   - One clock; reset is synchronous and active-high.
//   - Reset: state=IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; internal regs cleared.
//   - Reset overrides everything, including an in-flight op, which is aborted.
//   State IDLE
//   - start=1 at edge T0: latch A into shift reg SA.
//   - Latch B into shift reg SB, inverted when sub=1.
//   - Set carry reg C = sub and bit counter = 0; go to RUN.
//   State RUN (busy=1)
//   - Each edge T1..TWIDTH feeds SA[0], SB[0] and C to the cell.
//   - The cell's Sum bit shifts into result reg R from the MSB side.
//   - C <= cell Cout; SA and SB shift right; counter increments.
//   - At edge TWIDTH (last bit): capture carry-into-MSB (the C used for that bit).
//   - Same edge: Sum <= final R, Cout <= cell Cout, Ovf <= cin_msb ^ cell Cout.
//   - Same edge: go to DONE.
//   State DONE
//   - busy=0, done=1 for exactly one cycle.
//   - Next edge: go to IDLE, done=0.
//   Handshake and boundaries
//   - start while busy=1 is ignored; inputs are not re-sampled.
//   - start during DONE is accepted at that edge (busy=0 there).
//     This gives back-to-back ops with period WIDTH+1 cycles.
//   - Latency: start edge T0 -> done high in the cycle after edge TWIDTH.
//   - Sum/Cout/Ovf hold their last value until the next completion.
//   - They do not change during RUN; reset clears them.
//   - WIDTH=1: RUN lasts one edge; Ovf = carry-in ^ carry-out of bit 0.
//   - Counter width is clog2(WIDTH+1); the counter never wraps within one op.
// TESTING
//   1. WIDTH=8, A=0x5A, B=0x3C, sub=0 -> done 9 cycles after start.
//      Required: Sum=0x96, Cout=0, Ovf=1.
//   2. A=0xFF, B=0x01, sub=0 -> Sum=0x00, Cout=1, Ovf=0.
//      A=0x80, B=0x80 -> Sum=0x00, Cout=1, Ovf=1.
//   3. sub=1: A=0x10, B=0x20 -> Sum=0xF0, Cout=0, Ovf=0.
//      sub=1: A=0x20, B=0x10 -> Sum=0x10, Cout=1.
//   4. start pulsed again with new A/B mid-RUN -> ignored.
//      Result is for the original operands; done pulses exactly once.
//   5. reset asserted at edge T3 of an op -> next cycle: busy=0, done=0, Sum=0.
//      A new start after reset completes correctly.
//   6. start held high continuously, A=0x01, B=0x01 -> done every 9 cycles.
//      Each result Sum=0x02; busy low only in the done cycle.
//      Also run WIDTH=1: A=1, B=1 -> Sum=0, Cout=1, Ovf=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first,
//   through a single full-adder cell. For subtraction, B is inverted and the
//   carry is preset to 1, which gives the two's complement A - B.
//   Reports the final carry (for subtract: 1 = no borrow) and the signed
//   overflow.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; busy=0, done=0
//   RUN   | one operand bit per edge through the adder cell; busy=1
//   DONE  | results valid, done=1 for one cycle; a start here is accepted
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset; aborts an operation in flight
//   start  in   request, sampled only while busy=0
//   sub    in   0 = A+B, 1 = A-B, sampled with start
//   A, B   in   WIDTH-bit operands, sampled with start
//   busy   out  high while in RUN
//   done   out  one-cycle completion pulse
//   Sum    out  registered result, held until the next completion
//   Cout   out  final carry out of the MSB
//   Ovf    out  carry into MSB XOR carry out of MSB
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_cout;
  logic             last_bit;

  // The shared one-bit adder cell
  assign cell_sum  = sa[0] ^ sb[0] ^ c;
  assign cell_cout = ((sa[0] ^ sb[0]) & c) | (sa[0] & sb[0]);

  assign last_bit = (cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Result bits enter from the MSB side so that after WIDTH shifts the
  // first (LSB) result bit has landed in bit 0. Written this way so it also
  // holds for WIDTH=1.
  always_comb begin
    r_next            = r >> 1;
    r_next[WIDTH-1]   = cell_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      r     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= A;
            sb    <= sub ? ~B : B;
            c     <= sub;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= r_next;
          c   <= cell_cout;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            // c here is the carry into the MSB
            Sum   <= r_next;
            Cout  <= cell_cout;
            Ovf   <= c ^ cell_cout;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] esum;
    logic       ecout;
    logic       eovf;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout, ovf;

  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1, ovf1;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input int w, input longint ua, input longint ub, input bit sv);
    res_t   r;
    longint m, sa, sb, res;
    m  = longint'(1) << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    res = sv ? sa - sb : sa + sb;
    r.sum  = 32'(sv ? (ua - ub + m) % m : (ua + ub) % m);
    r.cout = sv ? (ua >= ub) : (ua + ub >= m);
    r.ovf  = (res >= m / 2) || (res < -(m / 2));
    return r;
  endfunction

  // Issues one WIDTH=8 operation and returns at the negedge where done is seen.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, output int lat);
    logic [7:0] prev;
    prev  = sum;
    start = 1'b1; a = av; b = bv; sub = sv;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      checks++;
      if (busy !== 1'b1 || sum !== prev) begin
        errors++;
        $display("FAIL run_phase: busy=%b sum=%h, required busy=1 sum=%h", busy, sum, prev);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; sub = 0; a = 0; b = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'h0) begin
      errors++;
      $display("FAIL reset_state_w1: busy=%b done=%b sum=%b cout=%b ovf=%b, required all 0",
               busy1, done1, sum1, cout1, ovf1);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    vec_t vt[5];
    int   lat;
    res_t m;
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vt[4] = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
    foreach (vt[i]) begin
      op8(vt[i].a, vt[i].b, vt[i].sub, lat);
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL directed_latency[%0d]: %0d cycles, required 9", i, lat);
      end
      checks++;
      if ({sum, cout, ovf} !== {vt[i].esum, vt[i].ecout, vt[i].eovf}) begin
        errors++;
        $display("FAIL directed_result[%0d]: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, vt[i].esum, vt[i].ecout, vt[i].eovf);
      end
      m = model(8, longint'(vt[i].a), longint'(vt[i].b), vt[i].sub);
      checks++;
      if ({sum, cout, ovf} !== {m.sum[7:0], m.cout, m.ovf}) begin
        errors++;
        $display("FAIL directed_model[%0d]: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, m.sum[7:0], m.cout, m.ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_one_cycle[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random;
    int         lat;
    res_t       m;
    logic [7:0] av, bv;
    logic       sv;
    for (int i = 0; i < 30; i++) begin
      av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
      op8(av, bv, sv, lat);
      m = model(8, longint'(av), longint'(bv), sv);
      checks++;
      if (lat != 9 || {sum, cout, ovf} !== {m.sum[7:0], m.cout, m.ovf}) begin
        errors++;
        $display("FAIL random[%0d] %h %s %h: lat=%0d sum=%h cout=%b ovf=%b, required lat=9 sum=%h cout=%b ovf=%b",
                 i, av, sv ? "-" : "+", bv, lat, sum, cout, ovf, m.sum[7:0], m.cout, m.ovf);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int         ndone, at;
    logic [7:0] rs;
    logic       rc, ro;
    res_t       m;
    start = 1; a = 8'h33; b = 8'h44; sub = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    start = 1; a = 8'hFF; b = 8'hFF; sub = 1;
    @(negedge clk);
    start = 0;
    ndone = 0; at = -1; rs = 0; rc = 0; ro = 0;
    for (int i = 4; i < 24; i++) begin
      if (done === 1'b1) begin
        ndone++;
        if (at < 0) begin at = i; rs = sum; rc = cout; ro = ovf; end
      end
      @(negedge clk);
    end
    m = model(8, 64'h33, 64'h44, 1'b0);
    checks++;
    if (ndone != 1 || at != 9) begin
      errors++;
      $display("FAIL start_ignored_done: pulses=%0d at cycle %0d, required 1 at cycle 9", ndone, at);
    end
    checks++;
    if ({rs, rc, ro} !== {m.sum[7:0], m.cout, m.ovf}) begin
      errors++;
      $display("FAIL start_ignored_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               rs, rc, ro, m.sum[7:0], m.cout, m.ovf);
    end
  endtask

  task automatic test_reset_midop;
    int   lat;
    res_t m;
    start = 1; a = 8'h12; b = 8'h34; sub = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    op8(8'h7F, 8'h01, 1'b0, lat);
    m = model(8, 64'h7F, 64'h01, 1'b0);
    checks++;
    if (lat != 9 || {sum, cout, ovf} !== {m.sum[7:0], m.cout, m.ovf}) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d sum=%h cout=%b ovf=%b, required lat=9 sum=%h cout=%b ovf=%b",
               lat, sum, cout, ovf, m.sum[7:0], m.cout, m.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int  ndone, last, wait_n;
    bit  seen;
    start = 1; a = 8'h01; b = 8'h01; sub = 0;
    ndone = 0; last = -1; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
      if (seen) begin
        checks++;
        if (busy !== ~done) begin
          errors++;
          $display("FAIL b2b_busy[%0d]: busy=%b done=%b, required busy=!done", i, busy, done);
        end
        if (done === 1'b1) begin
          ndone++;
          checks++;
          if (sum !== 8'h02 || (last >= 0 && i - last != 9)) begin
            errors++;
            $display("FAIL b2b_done[%0d]: sum=%h period=%0d, required sum=02 period=9", i, sum, i - last);
          end
          last = i;
        end
      end
    end
    start = 0;
    checks++;
    if (ndone < 6) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses, required at least 6", ndone);
    end
    wait_n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_width1;
    int   lat;
    res_t m;
    for (int k = 0; k < 8; k++) begin
      start1 = 1; a1 = 1'(k); b1 = 1'(k >> 1); sub1 = 1'(k >> 2);
      @(negedge clk);
      start1 = 0;
      lat = 1;
      while (done1 !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      m = model(1, longint'(k & 1), longint'((k >> 1) & 1), bit'((k >> 2) & 1));
      checks++;
      if (lat != 2 || {sum1, cout1, ovf1} !== {m.sum[0], m.cout, m.ovf}) begin
        errors++;
        $display("FAIL width1[%0d]: lat=%0d sum=%b cout=%b ovf=%b, required lat=2 sum=%b cout=%b ovf=%b",
                 k, lat, sum1, cout1, ovf1, m.sum[0], m.cout, m.ovf);
      end
      @(negedge clk);
    end
    start1 = 1; a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0;
    @(negedge clk);
    start1 = 0;
    @(negedge clk);
    checks++;
    if ({done1, sum1, cout1, ovf1} !== 4'b1011) begin
      errors++;
      $display("FAIL width1_1p1: done=%b sum=%b cout=%b ovf=%b, required done=1 sum=0 cout=1 ovf=1",
               done1, sum1, cout1, ovf1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midop();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
